// File: rtl/afficheur_pkg.sv
// Shared glyph codes, segment patterns and frame layout for the 4-digit display path.
package afficheur_pkg;

  localparam int unsigned CODE_W   = 4;
  localparam int unsigned SEG_W    = 7;
  localparam int unsigned DIGITS   = 4;
  localparam int unsigned IDX_W    = 2;

  localparam logic [CODE_W-1:0] CODE_BLANK = 4'd15;
  localparam logic [CODE_W-1:0] CODE_D     = 4'd14;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;

  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    SEG_BLANK,   // 10
    SEG_BLANK,   // 11
    SEG_BLANK,   // 12
    SEG_BLANK,   // 13
    SEG_D,       // 14
    SEG_BLANK    // 15
  };

  // One displayed frame: four glyph codes, digit 0 in the low nibble.
  typedef struct packed {
    logic [CODE_W-1:0] d;
    logic [CODE_W-1:0] cent;
    logic [CODE_W-1:0] diz;
    logic [CODE_W-1:0] unit;
  } frame_t;

  localparam frame_t FRAME_BLANK = '{
    d:    CODE_BLANK,
    cent: CODE_BLANK,
    diz:  CODE_BLANK,
    unit: CODE_BLANK
  };

  // Select the glyph code shown in digit slot idx.
  function automatic logic [CODE_W-1:0] frame_code(input frame_t f, input logic [IDX_W-1:0] idx);
    logic [CODE_W-1:0] code;
    case (idx)
      2'd0:    code = f.unit;
      2'd1:    code = f.diz;
      2'd2:    code = f.cent;
      default: code = f.d;
    endcase
    return code;
  endfunction

  // Active-low digit enable with only slot idx lit.
  function automatic logic [DIGITS-1:0] digit_an(input logic [IDX_W-1:0] idx);
    return ~(DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/afficheur_mux_dec7seg.sv
// Combinational glyph-code to active-low 7-segment decoder.
module dec7seg
  import afficheur_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [SEG_W-1:0]  seg_o
);

  // Table lookup; unused codes map to dark in the shared table.
  always_comb begin
    seg_o = SEG_TABLE[code_i];
  end

endmodule

// File: rtl/afficheur_mux.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame input snapshot.
module afficheur_mux
  import afficheur_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] unit,
  input  logic [CODE_W-1:0] diz,
  input  logic [CODE_W-1:0] cent,
  input  logic [CODE_W-1:0] d,
  input  logic              blank,
  output logic [DIGITS-1:0] an,
  output logic [SEG_W-1:0]  seg
);

  localparam int unsigned     CNT_W   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  frame_t            frame_q, frame_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]  seg_q, seg_d;

  logic              tick_c;
  logic              wrap_c;
  logic [CODE_W-1:0] code_c;
  logic [SEG_W-1:0]  glyph_c;

  // Glyph for the slot about to be shown, taken from the frame being latched.
  dec7seg u_dec (
    .code_i (code_c),
    .seg_o  (glyph_c)
  );

  // Prescaler, slot index and frame snapshot next-state.
  always_comb begin
    tick_c  = (cnt_q == CNT_MAX);
    wrap_c  = tick_c && (idx_q == IDX_W'(DIGITS - 1));
    cnt_d   = tick_c ? '0 : cnt_q + CNT_W'(1);
    idx_d   = tick_c ? idx_q + IDX_W'(1) : idx_q;
    frame_d = frame_q;
    if (wrap_c) begin
      frame_d = '{d: d, cent: cent, diz: diz, unit: unit};
    end
    code_c  = frame_code(frame_d, idx_d);
  end

  // Output next-state: dark while blanked, otherwise refreshed only on a tick.
  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    if (blank) begin
      an_d  = '1;
      seg_d = SEG_BLANK;
    end else if (tick_c) begin
      an_d  = digit_an(idx_d);
      seg_d = glyph_c;
    end
  end

  // State and output registers; reset parks on the last slot so the first tick wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= IDX_W'(DIGITS - 1);
      frame_q <= FRAME_BLANK;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_afficheur_mux.sv
// Scoreboard bench for afficheur_mux with a slot-arithmetic reference model.
module tb_afficheur_mux;

  localparam int SCAN_DIV = 4;

  logic       clk;
  logic       rst;
  logic [3:0] unit, diz, cent, d;
  logic       blank;
  logic [3:0] an;
  logic [6:0] seg;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t  exp_q[$];
  int    checks;
  int    errors;
  string phase;

  int         m_t;
  int         m_idx;
  logic [3:0] m_snap [4];
  logic [3:0] m_an;
  logic [6:0] m_seg;

  afficheur_mux #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .rst   (rst),
    .unit  (unit),
    .diz   (diz),
    .cent  (cent),
    .d     (d),
    .blank (blank),
    .an    (an),
    .seg   (seg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Standard decimal glyphs, lowercase d for 14, dark otherwise; {g,f,e,d,c,b,a} active-low.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      4'd14:   return 7'h21;
      default: return 7'h7F;
    endcase
  endfunction

  // Reference model: slot = elapsed cycles / SCAN_DIV, frame captured on entry to slot 0.
  initial begin
    m_t   = 0;
    m_idx = 3;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_t   = 0;
        m_idx = 3;
        for (int i = 0; i < 4; i++) m_snap[i] = 4'd15;
        m_an  = 4'hF;
        m_seg = 7'h7F;
      end else begin
        m_t = m_t + 1;
        if (m_t % SCAN_DIV == 0) begin
          m_idx = (3 + m_t / SCAN_DIV) % 4;
          if (m_idx == 0) begin
            m_snap[0] = unit;
            m_snap[1] = diz;
            m_snap[2] = cent;
            m_snap[3] = d;
          end
          if (!blank) begin
            m_an  = 4'(~(4'b0001 << m_idx));
            m_seg = glyph(m_snap[m_idx]);
          end
        end
        if (blank) begin
          m_an  = 4'hF;
          m_seg = 7'h7F;
        end
      end
      exp_q.push_back('{an: m_an, seg: m_seg});
    end
  end

  // Monitor: one expected response per clock edge, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks = checks + 1;
        if (an !== e.an || seg !== e.seg || !(an == 4'hF || $onehot(~an))) begin
          errors = errors + 1;
          $display("FAIL %s t=%0t: an=%b seg=%b expected an=%b seg=%b",
                   phase, $time, an, seg, e.an, e.seg);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance until the model is mid-slot at index target, bounded.
  task automatic wait_idx(input int target);
    int i;
    i = 0;
    while (m_idx != target && i < 64) begin
      @(negedge clk);
      i++;
    end
    checks = checks + 1;
    if (m_idx != target) begin
      errors = errors + 1;
      $display("FAIL wait_idx: index=%0d expected %0d", m_idx, target);
    end
    step(1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    phase  = "reset";
    rst    = 1'b1;
    blank  = 1'b0;
    unit   = 4'd4;
    diz    = 4'd14;
    cent   = 4'd15;
    d      = 4'd15;
    step(3);
    rst = 1'b0;

    phase = "full_scan";
    step(36);

    phase = "snapshot";
    wait_idx(1);
    unit = 4'd8;
    step(36);

    phase = "blank";
    wait_idx(2);
    blank = 1'b1;
    step(6);
    blank = 1'b0;
    step(24);

    phase = "decode_sweep";
    for (int c = 0; c < 16; c++) begin
      unit = 4'(c);
      step(16);
    end
    step(16);

    phase = "reset_mid_scan";
    wait_idx(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(40);

    phase = "random";
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        unit = 4'($urandom_range(0, 15));
        diz  = 4'($urandom_range(0, 15));
        cent = 4'($urandom_range(0, 15));
        d    = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 15) == 0) blank = ~blank;
      rst = ($urandom_range(0, 99) == 0);
      step(1);
    end
    rst   = 1'b0;
    blank = 1'b0;
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
